// File: rtl/regfile_write_scheduler_if.sv
// Register-file write-port bundle: WB/MDU/LSU requesters, busy-issue, decode checks
// and the registered regfile write port.
interface regfile_write_scheduler_if;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall_wb;

  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;

  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;

  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;

  logic        rf_wena;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           lsu_valid, lsu_addr, lsu_data, iss_valid, iss_addr, chk_addr1, chk_addr2,
    input  stall_wb, mdu_ready, lsu_ready, chk_busy1, chk_busy2, rf_wena, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           lsu_valid, lsu_addr, lsu_data, iss_valid, iss_addr, chk_addr1, chk_addr2,
    output stall_wb, mdu_ready, lsu_ready, chk_busy1, chk_busy2, rf_wena, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the regfile's single write port between WB (priority), MDU and LSU,
// with starvation-driven WB stalls and a busy scoreboard for long-latency writes.
module regfile_write_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input logic                       clk,
  input logic                       rst,
  regfile_write_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  typedef enum logic {RrMdu, RrLsu} rr_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  rr_e              rr_q, rr_d;
  logic [31:0]      busy_q, busy_d;
  logic             rf_wena_q, rf_wena_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic        starve;
  logic        gnt_wb, gnt_mdu, gnt_lsu, gnt_sec;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;

  // Grant: WB unless starving; otherwise round-robin among the secondaries.
  always_comb begin
    starve  = (cnt_q == Limit);
    gnt_wb  = 1'b0;
    gnt_mdu = 1'b0;
    gnt_lsu = 1'b0;
    if (!rst) begin
      if (!starve && bus.wb_valid) begin
        gnt_wb = 1'b1;
      end else if (bus.mdu_valid && bus.lsu_valid) begin
        gnt_mdu = (rr_q == RrMdu);
        gnt_lsu = (rr_q == RrLsu);
      end else begin
        gnt_mdu = bus.mdu_valid;
        gnt_lsu = bus.lsu_valid;
      end
    end
    gnt_sec  = gnt_mdu | gnt_lsu;
    gnt_addr = '0;
    gnt_data = '0;
    if (gnt_wb) begin
      gnt_addr = bus.wb_addr;
      gnt_data = bus.wb_data;
    end else if (gnt_mdu) begin
      gnt_addr = bus.mdu_addr;
      gnt_data = bus.mdu_data;
    end else if (gnt_lsu) begin
      gnt_addr = bus.lsu_addr;
      gnt_data = bus.lsu_data;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (!gnt_sec && (bus.mdu_valid || bus.lsu_valid)) begin
      cnt_d = starve ? cnt_q : cnt_q + 1'b1;
    end

    rr_d = rr_q;
    if (gnt_mdu) begin
      rr_d = RrLsu;
    end else if (gnt_lsu) begin
      rr_d = RrMdu;
    end

    // Clear first so a same-cycle issue to the same register keeps it busy.
    busy_d = busy_q;
    if (gnt_sec) begin
      busy_d[gnt_addr] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
      busy_d[bus.iss_addr] = 1'b1;
    end

    rf_wena_d  = (gnt_wb || gnt_sec) && (gnt_addr != 5'd0);
    rf_waddr_d = rf_wena_d ? gnt_addr : 5'd0;
    rf_wdata_d = rf_wena_d ? gnt_data : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      rr_q       <= RrMdu;
      busy_q     <= '0;
      rf_wena_q  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      busy_q     <= busy_d;
      rf_wena_q  <= rf_wena_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.stall_wb  = !rst && starve;
  assign bus.mdu_ready = gnt_mdu;
  assign bus.lsu_ready = gnt_lsu;
  assign bus.chk_busy1 = !rst && (bus.chk_addr1 != 5'd0) && busy_q[bus.chk_addr1];
  assign bus.chk_busy2 = !rst && (bus.chk_addr2 != 5'd0) && busy_q[bus.chk_addr2];
  assign bus.rf_wena   = rf_wena_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios with literal expectations,
// then constrained-random traffic checked every cycle against a behavioural model.
module tb_regfile_write_scheduler;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  regfile_write_scheduler_if bus ();

  regfile_write_scheduler #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: denied-cycle count, which secondary wins a tie, owed registers,
  // and the write expected to appear on the port after the next edge.
  int          m_cnt;
  int          m_pref;  // 0: MDU wins a tie, 1: LSU wins
  bit          m_busy [32];
  logic        exp_wena;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  bit          wb_acc, mdu_acc, lsu_acc;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_cnt     = 0;
    m_pref    = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    exp_wena  = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    wb_acc    = 1'b0;
    mdu_acc   = 1'b0;
    lsu_acc   = 1'b0;
  endfunction

  // Runs at the falling edge: compare every output, then advance the model
  // to what the next rising edge must produce.
  task automatic model_step();
    int          who;  // 0 none, 1 WB, 2 MDU, 3 LSU
    bit          starve;
    logic [4:0]  a;
    logic [31:0] d;
    if (rst) begin
      model_reset();
      chk("rst_stall_wb", 32'(bus.stall_wb), 0);
      chk("rst_mdu_ready", 32'(bus.mdu_ready), 0);
      chk("rst_lsu_ready", 32'(bus.lsu_ready), 0);
      chk("rst_chk_busy1", 32'(bus.chk_busy1), 0);
      chk("rst_chk_busy2", 32'(bus.chk_busy2), 0);
      chk("rst_rf_wena", 32'(bus.rf_wena), 0);
      chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
      chk("rst_rf_wdata", bus.rf_wdata, 0);
      return;
    end
    chk("rf_wena", 32'(bus.rf_wena), 32'(exp_wena));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(exp_waddr));
    chk("rf_wdata", bus.rf_wdata, exp_wdata);

    starve = (m_cnt == STARVE_LIMIT);
    if (!starve && bus.wb_valid) who = 1;
    else if (bus.mdu_valid && bus.lsu_valid) who = (m_pref == 0) ? 2 : 3;
    else if (bus.mdu_valid) who = 2;
    else if (bus.lsu_valid) who = 3;
    else who = 0;

    chk("stall_wb", 32'(bus.stall_wb), 32'(starve));
    chk("mdu_ready", 32'(bus.mdu_ready), 32'(who == 2));
    chk("lsu_ready", 32'(bus.lsu_ready), 32'(who == 3));
    chk("chk_busy1", 32'(bus.chk_busy1), 32'(bus.chk_addr1 != 0 && m_busy[bus.chk_addr1]));
    chk("chk_busy2", 32'(bus.chk_busy2), 32'(bus.chk_addr2 != 0 && m_busy[bus.chk_addr2]));

    case (who)
      1: begin a = bus.wb_addr;  d = bus.wb_data;  end
      2: begin a = bus.mdu_addr; d = bus.mdu_data; end
      3: begin a = bus.lsu_addr; d = bus.lsu_data; end
      default: begin a = '0; d = '0; end
    endcase
    exp_wena  = (who != 0) && (a != 0);
    exp_waddr = exp_wena ? a : 5'd0;
    exp_wdata = exp_wena ? d : 32'd0;

    if (who >= 2) m_busy[a] = 1'b0;
    if (bus.iss_valid && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;

    if (who >= 2) m_cnt = 0;
    else if (bus.mdu_valid || bus.lsu_valid) m_cnt = (m_cnt < STARVE_LIMIT) ? m_cnt + 1 : m_cnt;
    else m_cnt = 0;

    if (who == 2) m_pref = 1;
    if (who == 3) m_pref = 0;

    wb_acc  = (who == 1);
    mdu_acc = (who == 2);
    lsu_acc = (who == 3);
  endtask

  // One clock: check at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    bus.wb_valid = 1'b1;  bus.wb_addr = 5'd5;   bus.wb_data = 32'h1234_5678;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd8;  bus.mdu_data = 32'h0000_0088;
    bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd9;  bus.lsu_data = 32'h0000_0099;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
    bus.chk_addr1 = 5'd3; bus.chk_addr2 = 5'd8;
    #2 rst = 1'b1;
    #1;
    chk("lit_rst_mdu_ready", 32'(bus.mdu_ready), 0);
    chk("lit_rst_stall_wb", 32'(bus.stall_wb), 0);
    chk("lit_rst_chk_busy1", 32'(bus.chk_busy1), 0);
    repeat (3) cycle();

    // Release with everyone requesting: WB goes first.
    rst = 1'b0;
    bus.iss_valid = 1'b0;
    bus.wb_data = 32'hDEAD_BEEF;
    #1;
    chk("lit_first_mdu_ready", 32'(bus.mdu_ready), 0);
    cycle();
    chk("lit_wb_wena", 32'(bus.rf_wena), 1);
    chk("lit_wb_waddr", 32'(bus.rf_waddr), 5);
    chk("lit_wb_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    bus.wb_addr = 5'd0;
    cycle();
    chk("lit_wb_r0_wena", 32'(bus.rf_wena), 0);

    // Round-robin: MDU first after reset, then LSU.
    bus.wb_valid = 1'b0;
    #1;
    chk("lit_rr_mdu_ready", 32'(bus.mdu_ready), 1);
    chk("lit_rr_lsu_wait", 32'(bus.lsu_ready), 0);
    cycle();
    bus.mdu_valid = 1'b0;
    chk("lit_rr_waddr8", 32'(bus.rf_waddr), 8);
    #1;
    chk("lit_rr_lsu_ready", 32'(bus.lsu_ready), 1);
    cycle();
    bus.lsu_valid = 1'b0;
    chk("lit_rr_waddr9", 32'(bus.rf_waddr), 9);

    // Starvation: LSU waits STARVE_LIMIT cycles behind WB, then WB is stalled.
    bus.wb_valid = 1'b1;  bus.wb_addr = 5'd1;   bus.wb_data = 32'h0000_0011;
    bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd12; bus.lsu_data = 32'h00C0_FFEE;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lit_starve_lsu_denied", 32'(bus.lsu_ready), 0);
      cycle();
    end
    #1;
    chk("lit_starve_stall", 32'(bus.stall_wb), 1);
    chk("lit_starve_lsu_ready", 32'(bus.lsu_ready), 1);
    cycle();
    bus.lsu_valid = 1'b0;
    chk("lit_starve_waddr12", 32'(bus.rf_waddr), 12);
    #1;
    chk("lit_starve_unstall", 32'(bus.stall_wb), 0);
    cycle();
    chk("lit_wb_resumes", 32'(bus.rf_waddr), 1);

    // Scoreboard set by issue, cleared by the MDU write.
    bus.wb_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd10; bus.chk_addr1 = 5'd10;
    cycle();
    bus.iss_valid = 1'b0;
    #1;
    chk("lit_busy10_set", 32'(bus.chk_busy1), 1);
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd10; bus.mdu_data = 32'h0000_00AA;
    cycle();
    bus.mdu_valid = 1'b0;
    chk("lit_mdu10_wena", 32'(bus.rf_wena), 1);
    chk("lit_mdu10_waddr", 32'(bus.rf_waddr), 10);
    chk("lit_busy10_clr", 32'(bus.chk_busy1), 0);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0; bus.chk_addr1 = 5'd0;
    cycle();
    bus.iss_valid = 1'b0;
    #1;
    chk("lit_busy0_never", 32'(bus.chk_busy1), 0);

    // Same-cycle set and clear of r7: set wins; WB writes never clear.
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7; bus.chk_addr2 = 5'd7;
    cycle();
    bus.lsu_valid = 1'b1; bus.lsu_addr = 5'd7; bus.lsu_data = 32'h0000_0077;
    #1;
    chk("lit_coll_lsu_ready", 32'(bus.lsu_ready), 1);
    cycle();
    bus.iss_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    #1;
    chk("lit_coll_busy7", 32'(bus.chk_busy2), 1);
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_0707;
    cycle();
    bus.wb_valid = 1'b0;
    chk("lit_wb7_waddr", 32'(bus.rf_waddr), 7);
    #1;
    chk("lit_wb7_busy_kept", 32'(bus.chk_busy2), 1);

    // Random traffic; requesters hold their request until the model says accepted.
    for (int n = 0; n < 4000; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 699) == 0) rst = 1'b1;
      if (!bus.wb_valid || wb_acc) begin
        bus.wb_valid = ($urandom_range(0, 9) < 6);
        bus.wb_addr  = rnd_addr();
        bus.wb_data  = $urandom;
      end
      if (!bus.mdu_valid || mdu_acc) begin
        bus.mdu_valid = ($urandom_range(0, 9) < 4);
        bus.mdu_addr  = rnd_addr();
        bus.mdu_data  = $urandom;
      end
      if (!bus.lsu_valid || lsu_acc) begin
        bus.lsu_valid = ($urandom_range(0, 9) < 3);
        bus.lsu_addr  = rnd_addr();
        bus.lsu_data  = $urandom;
      end
      bus.iss_valid = ($urandom_range(0, 9) < 3);
      bus.iss_addr  = rnd_addr();
      bus.chk_addr1 = rnd_addr();
      bus.chk_addr2 = rnd_addr();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
